// File: rtl/jtag_pkg.sv
// Shared TAP definitions: controller state encoding, default opcodes and the
// rule that an all-ones instruction always selects BYPASS.
package jtag_pkg;

  typedef enum logic [3:0] {
    ST_RESET      = 4'd0,
    ST_RUN_IDLE   = 4'd1,
    ST_SELECT_DR  = 4'd2,
    ST_CAPTURE_DR = 4'd3,
    ST_SHIFT_DR   = 4'd4,
    ST_EXIT1_DR   = 4'd5,
    ST_PAUSE_DR   = 4'd6,
    ST_EXIT2_DR   = 4'd7,
    ST_UPDATE_DR  = 4'd8,
    ST_SELECT_IR  = 4'd9,
    ST_CAPTURE_IR = 4'd10,
    ST_SHIFT_IR   = 4'd11,
    ST_EXIT1_IR   = 4'd12,
    ST_PAUSE_IR   = 4'd13,
    ST_EXIT2_IR   = 4'd14,
    ST_UPDATE_IR  = 4'd15
  } tap_state_e;

  localparam logic [31:0] DEFAULT_IDCODE_VALUE = 32'h1000_0001;
  localparam logic [3:0]  DEFAULT_IDCODE_OP    = 4'h1;
  localparam logic [3:0]  DEFAULT_USER_BASE    = 4'h8;

  // True when the low 'width' bits of op are all ones (the BYPASS opcode).
  function automatic logic is_bypass_op(input logic [31:0] op, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (op & mask) == mask;
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP controller: state register plus the standard TMS transition graph.
module tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       reset_bar,
  input  logic       TMS,
  output tap_state_e tap_state
);

  tap_state_e state_next;

  // State register; TRST* forces Test-Logic-Reset immediately.
  always_ff @(posedge TCK or negedge reset_bar) begin
    if (!reset_bar) tap_state <= ST_RESET;
    else            tap_state <= state_next;
  end

  // Next state from the current state and TMS.
  always_comb begin
    state_next = tap_state;
    case (tap_state)
      ST_RESET:      state_next = TMS ? ST_RESET     : ST_RUN_IDLE;
      ST_RUN_IDLE:   state_next = TMS ? ST_SELECT_DR : ST_RUN_IDLE;
      ST_SELECT_DR:  state_next = TMS ? ST_SELECT_IR : ST_CAPTURE_DR;
      ST_CAPTURE_DR: state_next = TMS ? ST_EXIT1_DR  : ST_SHIFT_DR;
      ST_SHIFT_DR:   state_next = TMS ? ST_EXIT1_DR  : ST_SHIFT_DR;
      ST_EXIT1_DR:   state_next = TMS ? ST_UPDATE_DR : ST_PAUSE_DR;
      ST_PAUSE_DR:   state_next = TMS ? ST_EXIT2_DR  : ST_PAUSE_DR;
      ST_EXIT2_DR:   state_next = TMS ? ST_UPDATE_DR : ST_SHIFT_DR;
      ST_UPDATE_DR:  state_next = TMS ? ST_SELECT_DR : ST_RUN_IDLE;
      ST_SELECT_IR:  state_next = TMS ? ST_RESET     : ST_CAPTURE_IR;
      ST_CAPTURE_IR: state_next = TMS ? ST_EXIT1_IR  : ST_SHIFT_IR;
      ST_SHIFT_IR:   state_next = TMS ? ST_EXIT1_IR  : ST_SHIFT_IR;
      ST_EXIT1_IR:   state_next = TMS ? ST_UPDATE_IR : ST_PAUSE_IR;
      ST_PAUSE_IR:   state_next = TMS ? ST_EXIT2_IR  : ST_PAUSE_IR;
      ST_EXIT2_IR:   state_next = TMS ? ST_UPDATE_IR : ST_SHIFT_IR;
      ST_UPDATE_IR:  state_next = TMS ? ST_SELECT_DR : ST_RUN_IDLE;
      default:       state_next = ST_RESET;
    endcase
  end

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG TAP core: controller, instruction register, decode, IDCODE and BYPASS
// registers and the TDO mux, all in the TCK domain. User DRs live outside and
// are steered by user_select and the DR strobes.
module jtag_tap_core
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = DEFAULT_IDCODE_VALUE,
  parameter int                  NUM_USER     = 2,
  parameter logic [IR_WIDTH-1:0] USER_BASE    = IR_WIDTH'(DEFAULT_USER_BASE),
  parameter logic [IR_WIDTH-1:0] IDCODE_OP    = IR_WIDTH'(DEFAULT_IDCODE_OP)
)(
  input  logic                TCK,
  input  logic                reset_bar,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                enableTDO,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic [3:0]          tap_state,
  output logic [NUM_USER-1:0] user_select,
  input  logic [NUM_USER-1:0] user_tdo,
  output logic                captureDR,
  output logic                shiftDR,
  output logic                updateDR
);

  tap_state_e          state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_reg;
  logic [31:0]         idcode_sr;
  logic                bypass_sr;
  logic                sel_idcode;
  logic                user_any;
  logic [NUM_USER-1:0] user_hit;
  logic                tdo_next;

  tap_fsm u_fsm (
    .TCK       (TCK),
    .reset_bar (reset_bar),
    .TMS       (TMS),
    .tap_state (state)
  );

  assign tap_state = state;

  // The instruction reads as IDCODE for as long as the controller sits in Reset.
  assign ir_out = (state == ST_RESET) ? IDCODE_OP : ir_reg;

  // IR capture/shift and the parallel instruction latch.
  always_ff @(posedge TCK or negedge reset_bar) begin
    if (!reset_bar) begin
      ir_shift <= '0;
      ir_reg   <= IDCODE_OP;
    end else begin
      case (state)
        ST_RESET:      ir_reg   <= IDCODE_OP;
        ST_CAPTURE_IR: ir_shift <= IR_WIDTH'(1);
        ST_SHIFT_IR:   ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        ST_UPDATE_IR:  ir_reg   <= ir_shift;
        default:       ;
      endcase
    end
  end

  // Instruction decode; all-ones wins over every other match, then IDCODE.
  always_comb begin
    sel_idcode = (ir_out == IDCODE_OP) && !is_bypass_op(32'(ir_out), IR_WIDTH);
    user_hit   = '0;
    for (int k = 0; k < NUM_USER; k++) begin
      user_hit[k] = (ir_out == USER_BASE + IR_WIDTH'(k));
    end
    if (sel_idcode || is_bypass_op(32'(ir_out), IR_WIDTH)) user_hit = '0;
  end

  assign user_select = user_hit;
  assign user_any    = |user_hit;
  assign captureDR   = user_any && (state == ST_CAPTURE_DR);
  assign shiftDR     = user_any && (state == ST_SHIFT_DR);
  assign updateDR    = user_any && (state == ST_UPDATE_DR);

  // Built-in data registers: IDCODE and the single-bit BYPASS.
  always_ff @(posedge TCK or negedge reset_bar) begin
    if (!reset_bar) begin
      idcode_sr <= '0;
      bypass_sr <= 1'b0;
    end else if (state == ST_CAPTURE_DR) begin
      idcode_sr <= IDCODE_VALUE;
      bypass_sr <= 1'b0;
    end else if (state == ST_SHIFT_DR) begin
      idcode_sr <= {TDI, idcode_sr[31:1]};
      bypass_sr <= TDI;
    end
  end

  // Serial output source for the current state and instruction.
  always_comb begin
    tdo_next = 1'b0;
    if (state == ST_SHIFT_IR) begin
      tdo_next = ir_shift[0];
    end else if (state == ST_SHIFT_DR) begin
      if (sel_idcode)    tdo_next = idcode_sr[0];
      else if (user_any) tdo_next = |(user_hit & user_tdo);
      else               tdo_next = bypass_sr;
    end
  end

  // TDO and its enable are retimed to the falling edge of TCK.
  always_ff @(negedge TCK or negedge reset_bar) begin
    if (!reset_bar) begin
      TDO       <= 1'b0;
      enableTDO <= 1'b0;
    end else begin
      TDO       <= tdo_next;
      enableTDO <= (state == ST_SHIFT_DR) || (state == ST_SHIFT_IR);
    end
  end

endmodule

// File: tb/tb_jtag_tap_core.sv
// Scoreboard bench for jtag_tap_core: scan tasks push the expected TDO stream,
// a monitor pops and compares every enabled TDO bit and counts DR strobes.
module tb_jtag_tap_core;

  localparam int          IRW     = 4;
  localparam logic [31:0] IDV     = 32'h1000_0001;
  localparam int          NU      = 2;
  localparam logic [3:0]  UBASE   = 4'h8;
  localparam logic [3:0]  IDOP    = 4'h1;
  localparam int          UDR_LEN = 8;

  logic TCK = 1'b0, reset_bar = 1'b1, TMS = 1'b1, TDI = 1'b0;
  logic TDO, enableTDO, captureDR, shiftDR, updateDR;
  logic [IRW-1:0] ir_out;
  logic [3:0]     tap_state;
  logic [NU-1:0]  user_select, user_tdo;

  jtag_tap_core #(
    .IR_WIDTH(IRW), .IDCODE_VALUE(IDV), .NUM_USER(NU),
    .USER_BASE(UBASE), .IDCODE_OP(IDOP)
  ) dut (
    .TCK(TCK), .reset_bar(reset_bar), .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .enableTDO(enableTDO), .ir_out(ir_out), .tap_state(tap_state),
    .user_select(user_select), .user_tdo(user_tdo),
    .captureDR(captureDR), .shiftDR(shiftDR), .updateDR(updateDR)
  );

  always #5 TCK = ~TCK;

  // External user data registers, acting on the posedge that leaves each state.
  logic [UDR_LEN-1:0] udr        [NU];
  logic [UDR_LEN-1:0] udr_cap    [NU];
  logic [UDR_LEN-1:0] udr_shadow [NU];

  always @(posedge TCK) begin
    for (int k = 0; k < NU; k++) begin
      if (user_select[k]) begin
        if (captureDR)    udr[k] <= udr_cap[k];
        else if (shiftDR) udr[k] <= {TDI, udr[k][UDR_LEN-1:1]};
        if (updateDR)     udr_shadow[k] <= udr[k];
      end
    end
  end

  always_comb begin
    user_tdo = '0;
    for (int k = 0; k < NU; k++) user_tdo[k] = udr[k][0];
  end

  int checks = 0;
  int failures = 0;
  bit exp_q[$];
  bit chk_tdo = 1'b0;
  int n_cap = 0, n_shift = 0, n_upd = 0;

  // Reference TAP graph: successor for TMS=0 and TMS=1.
  int unsigned nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int unsigned nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int unsigned mst = 0;
  logic [IRW-1:0] m_ir = IDOP;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Instruction -> one-hot user select, from the decode rules.
  function automatic logic [NU-1:0] model_sel(input logic [IRW-1:0] op);
    logic [NU-1:0] s;
    s = '0;
    if (op != '1 && op != IDOP)
      for (int k = 0; k < NU; k++)
        if (int'(op) == int'(UBASE) + k) s[k] = 1'b1;
    return s;
  endfunction

  // A length-L shift register captured with cap emits cap first, then TDI delayed by L.
  function automatic bit stream_bit(input int L, input logic [63:0] cap, input bit tdi[$], input int j);
    if (j < L) return cap[j];
    return tdi[j-L];
  endfunction

  // Monitor: compare every enabled TDO bit with the scoreboard, count strobes.
  initial begin
    bit e;
    forever begin
      @(negedge TCK);
      #1;
      if (reset_bar) begin
        if (captureDR) n_cap++;
        if (shiftDR)   n_shift++;
        if (updateDR)  n_upd++;
        if (chk_tdo && enableTDO) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tdo_extra enableTDO=1 with no expected bit at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("tdo_bit", 64'(TDO), 64'(e));
          end
        end
      end
    end
  end

  task automatic clk(input bit tms, input bit tdi);
    @(negedge TCK);
    #2;
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
    mst = tms ? nxt1[mst] : nxt0[mst];
    chk("tap_state", 64'(tap_state), 64'(mst));
  endtask

  task automatic scan_ir(input logic [IRW-1:0] op);
    bit tdi[$];
    for (int i = 0; i < IRW; i++) tdi.push_back(op[i]);
    clk(1, 0); clk(1, 0); clk(0, 0); clk(0, 0);
    for (int j = 0; j < IRW; j++) exp_q.push_back(stream_bit(IRW, 64'd1, tdi, j));
    for (int j = 0; j < IRW; j++) clk(j == IRW - 1, tdi[j]);
    clk(1, 0);
    chk("ir_hold_update", 64'(ir_out), 64'(m_ir));
    chk("sel_hold_update", 64'(user_select), 64'(model_sel(m_ir)));
    clk(0, 0);
    m_ir = op;
    chk("ir_out", 64'(ir_out), 64'(m_ir));
    chk("user_select", 64'(user_select), 64'(model_sel(m_ir)));
    chk("ir_tdo_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic scan_dr(input bit tdi[$]);
    int n, L, k, c0, s0, u0;
    logic [63:0] cap;
    logic [NU-1:0] sel;
    logic [UDR_LEN-1:0] sh;
    n = tdi.size();
    sel = model_sel(m_ir);
    k = -1;
    for (int i = 0; i < NU; i++) if (sel[i]) k = i;
    if (m_ir != '1 && m_ir == IDOP) begin L = 32;      cap = 64'(IDV); end
    else if (k >= 0)                begin L = UDR_LEN; cap = 64'(udr_cap[k]); end
    else                            begin L = 1;       cap = '0; end
    for (int j = 0; j < n; j++) exp_q.push_back(stream_bit(L, cap, tdi, j));
    c0 = n_cap; s0 = n_shift; u0 = n_upd;
    clk(1, 0); clk(0, 0); clk(0, 0);
    for (int j = 0; j < n; j++) clk(j == n - 1, tdi[j]);
    clk(1, 0); clk(0, 0);
    chk("dr_tdo_drained", 64'(exp_q.size()), 64'd0);
    chk("user_select_dr", 64'(user_select), 64'(sel));
    chk("capture_cnt", 64'(n_cap - c0), (k >= 0) ? 64'd1 : 64'd0);
    chk("shift_cnt", 64'(n_shift - s0), (k >= 0) ? 64'(n) : 64'd0);
    chk("update_cnt", 64'(n_upd - u0), (k >= 0) ? 64'd1 : 64'd0);
    if (k >= 0) begin
      for (int i = 0; i < UDR_LEN; i++) sh[i] = stream_bit(L, cap, tdi, n + i);
      chk("user_update", 64'(udr_shadow[k]), 64'(sh));
    end
  endtask

  // Drop TRST* while bit nb of a DR shift (TDI held at 1) is on TDO.
  task automatic abort_shift(input int nb);
    bit tdi[$];
    int L;
    logic [63:0] cap;
    for (int j = 0; j < nb; j++) tdi.push_back(1'b1);
    if (m_ir == IDOP) begin L = 32; cap = 64'(IDV); end
    else              begin L = 1;  cap = '0; end
    for (int j = 0; j <= nb; j++) exp_q.push_back(stream_bit(L, cap, tdi, j));
    clk(1, 0); clk(0, 0); clk(0, 0);
    for (int j = 0; j < nb; j++) clk(0, tdi[j]);
    @(negedge TCK);
    #2;
    chk_tdo = 1'b0;
    reset_bar = 1'b0;
    #1;
    chk("abort_tdo", 64'(TDO), 64'd0);
    chk("abort_en", 64'(enableTDO), 64'd0);
    chk("abort_state", 64'(tap_state), 64'd0);
    chk("abort_ir", 64'(ir_out), 64'(IDOP));
    chk("abort_sel", 64'(user_select), 64'd0);
    chk("abort_strobes", 64'({captureDR, shiftDR, updateDR}), 64'd0);
    chk("abort_drained", 64'(exp_q.size()), 64'd0);
    @(negedge TCK);
    #2;
    TMS = 1'b1;
    reset_bar = 1'b1;
    mst = 0;
    m_ir = IDOP;
    clk(1, 0);
    chk("ir_after_abort", 64'(ir_out), 64'(IDOP));
    chk_tdo = 1'b1;
    clk(0, 0);
  endtask

  // Bound the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // Navigation paths from Reset to each state, TMS bits LSB first.
  int          plen  [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
  logic [7:0]  pbits [16] = '{8'd0, 8'd0, 8'd2, 8'd2, 8'd2, 8'd10, 8'd10, 8'd42,
                              8'd26, 8'd6, 8'd6, 8'd6, 8'd22, 8'd22, 8'd86, 8'd54};

  initial begin
    bit q[$];
    logic [7:0] pb;
    logic [IRW-1:0] op;
    #1 reset_bar = 1'b0;
    #1;
    chk("rst_state", 64'(tap_state), 64'd0);
    chk("rst_ir", 64'(ir_out), 64'(IDOP));
    chk("rst_tdo", 64'({TDO, enableTDO}), 64'd0);
    chk("rst_sel", 64'(user_select), 64'd0);
    chk("rst_strobes", 64'({captureDR, shiftDR, updateDR}), 64'd0);
    @(negedge TCK);
    #2 reset_bar = 1'b1;
    mst = 0;

    // Five TMS=1 clocks from every state land in Reset.
    for (int s = 0; s < 16; s++) begin
      for (int i = 0; i < 5; i++) clk(1, 0);
      pb = pbits[s];
      for (int i = 0; i < plen[s]; i++) clk(pb[i], 0);
      chk("reach_state", 64'(tap_state), 64'(s));
      for (int i = 0; i < 5; i++) clk(1, 0);
      chk("five_tms_reset", 64'(tap_state), 64'd0);
    end
    m_ir = IDOP;
    chk("ir_in_reset", 64'(ir_out), 64'(IDOP));

    chk_tdo = 1'b1;
    clk(0, 0);
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(1'b0);
    scan_dr(q);

    scan_ir(4'hF);
    q = '{1'b1, 1'b0, 1'b1, 1'b1};
    scan_dr(q);

    for (int k = 0; k < NU; k++) udr_cap[k] = UDR_LEN'($urandom);
    scan_ir(UBASE + 4'd1);
    q.delete();
    for (int i = 0; i < 12; i++) q.push_back(1'($urandom_range(0, 1)));
    scan_dr(q);

    scan_ir(4'hC);
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(1'($urandom_range(0, 1)));
    scan_dr(q);

    scan_ir(UBASE);
    q.delete();
    for (int i = 0; i < 5; i++) q.push_back(1'($urandom_range(0, 1)));
    scan_dr(q);

    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < NU; k++) udr_cap[k] = UDR_LEN'($urandom);
      op = IRW'($urandom_range(0, 15));
      scan_ir(op);
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) q.push_back(1'($urandom_range(0, 1)));
      scan_dr(q);
    end

    scan_ir(IDOP);
    abort_shift(10);
    scan_ir(4'hF);
    abort_shift(5);
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(1'($urandom_range(0, 1)));
    scan_dr(q);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
